vram_arbiter: RTL and testbench

Single-port VRAM arbiter between the character/pixel fetch engine of the video controller and a CPU-side read/write port. Video fetches have absolute priority and fixed latency, so raster timing is never disturbed. CPU accesses take the idle bus slots through a req/ack handshake. The block sits between the video controller's VRAM address/data pins and the synchronous VRAM (1-cycle read latency).

---
 rtl/vram_arbiter_pkg.sv | 27 ++
 rtl/vram_arbiter_if.sv | 34 +++
 rtl/vram_arbiter_wpost_fifo.sv | 52 +++++
 rtl/vram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM arbiter: default widths, return-data owner tags
// and the CPU-port state encoding.
package zed64_vram_pkg;

  localparam int DEF_ADDR_W       = 13;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_STARVE_LIMIT = 64;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  typedef enum logic [2:0] {
    C_IDLE = 3'd0,
    C_WR   = 3'd1,
    C_RD1  = 3'd2,
    C_RD2  = 3'd3,
    C_ACK  = 3'd4
  } cpu_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : (value + 8'd1);
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Signal bundle between the video fetch engine, the CPU port, the synchronous
// VRAM and the arbiter. The arbiter uses the slave view.
interface vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_adr;
  logic [DATA_W-1:0] vid_dat;
  logic              vid_valid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_wdat;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdat;
  logic              cpu_starve;
  logic [ADDR_W-1:0] vram_adr;
  logic              vram_we;
  logic [DATA_W-1:0] vram_wdat;
  logic [DATA_W-1:0] vram_dat_in;

  modport slave (
    input  vid_req, vid_adr, cpu_req, cpu_we, cpu_adr, cpu_wdat, vram_dat_in,
    output vid_dat, vid_valid, cpu_ack, cpu_rdat, cpu_starve,
           vram_adr, vram_we, vram_wdat
  );

  modport master (
    output vid_req, vid_adr, cpu_req, cpu_we, cpu_adr, cpu_wdat, vram_dat_in,
    input  vid_dat, vid_valid, cpu_ack, cpu_rdat, cpu_starve,
           vram_adr, vram_we, vram_wdat
  );
endinterface

// File: rtl/vram_arbiter_wpost_fifo.sv
// Four-entry {address, data} write-posting FIFO for the VRAM arbiter.
// Only compiled when VRAM_ARB_WPOST_EN is defined.
`ifdef VRAM_ARB_WPOST_EN
module vram_wpost_fifo #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_adr,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_pop,
  output logic [ADDR_W-1:0] o_adr,
  output logic [DATA_W-1:0] o_dat,
  output logic              o_full,
  output logic              o_empty
);
  logic [ADDR_W+DATA_W-1:0] r_mem [0:3];
  logic [1:0]               r_wr_ptr;
  logic [1:0]               r_rd_ptr;
  logic [2:0]               r_count;
  logic                     w_do_push;
  logic                     w_do_pop;

  assign o_full    = (r_count == 3'd4);
  assign o_empty   = (r_count == 3'd0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign {o_adr, o_dat} = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= {i_adr, i_dat};
  end
endmodule
`endif

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches own the bus with fixed 3-cycle latency,
// the CPU port takes idle slots. VRAM_ARB_WPOST_EN adds a 4-entry write-posting FIFO.
module vram_arbiter
  import zed64_vram_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic           pixel_clock,
  input logic           reset_n,
  vram_arbiter_if.slave bus
);
  localparam logic [7:0] STARVE_THR = 8'(STARVE_LIMIT);

  cpu_state_t        r_state;
  cpu_state_t        w_state_nxt;
  owner_t            r_tag0;
  owner_t            r_tag1;
  logic [ADDR_W-1:0] r_vram_adr;
  logic              r_vram_we;
  logic [DATA_W-1:0] r_vram_wdat;
  logic [DATA_W-1:0] r_vid_dat;
  logic              r_vid_valid;
  logic              r_cpu_ack;
  logic [DATA_W-1:0] r_cpu_rdat;
  logic [7:0]        r_starve_cnt;
  logic              r_cpu_starve;
  logic [7:0]        w_starve_nxt;
  logic              w_grant_rd;
  logic              w_grant_wr;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_cpu_bus;
  logic              w_drain;
  logic [ADDR_W-1:0] w_drain_adr;
  logic [DATA_W-1:0] w_drain_dat;

`ifdef VRAM_ARB_WPOST_EN
  logic w_fifo_full;
  logic w_fifo_empty;

  vram_wpost_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wpost_fifo (
    .clk     (pixel_clock),
    .rst_n   (reset_n),
    .i_push  (w_grant_wr),
    .i_adr   (bus.cpu_adr),
    .i_dat   (bus.cpu_wdat),
    .i_pop   (w_drain),
    .o_adr   (w_drain_adr),
    .o_dat   (w_drain_dat),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Posted writes never need the bus; reads wait for the FIFO to empty to keep RAW order.
  assign w_drain   = !w_fifo_empty && !bus.vid_req;
  assign w_wr_ok   = !w_fifo_full;
  assign w_rd_ok   = w_fifo_empty && !bus.vid_req;
  assign w_cpu_bus = w_grant_rd;
  localparam cpu_state_t WR_NEXT = C_ACK;
`else
  assign w_drain     = 1'b0;
  assign w_drain_adr = '0;
  assign w_drain_dat = '0;
  assign w_wr_ok     = !bus.vid_req;
  assign w_rd_ok     = !bus.vid_req;
  assign w_cpu_bus   = w_grant_rd || w_grant_wr;
  localparam cpu_state_t WR_NEXT = C_WR;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_rd  = 1'b0;
    w_grant_wr  = 1'b0;
    case (r_state)
      C_IDLE: begin
        if (bus.cpu_req && bus.cpu_we && w_wr_ok) begin
          w_grant_wr  = 1'b1;
          w_state_nxt = WR_NEXT;
        end else if (bus.cpu_req && !bus.cpu_we && w_rd_ok) begin
          w_grant_rd  = 1'b1;
          w_state_nxt = C_RD1;
        end else begin
          w_state_nxt = C_IDLE;
        end
      end
      C_WR:    w_state_nxt = C_IDLE;
      C_RD1:   w_state_nxt = C_RD2;
      C_RD2:   w_state_nxt = C_ACK;
      C_ACK:   w_state_nxt = C_IDLE;
      default: w_state_nxt = C_IDLE;
    endcase
  end

  // Counts only cycles spent waiting in C_IDLE; any grant or withdrawn request clears it.
  always_comb begin
    if ((r_state == C_IDLE) && bus.cpu_req && !(w_grant_rd || w_grant_wr)) begin
      w_starve_nxt = sat_inc8(r_starve_cnt);
    end else begin
      w_starve_nxt = 8'd0;
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= C_IDLE;
      r_cpu_ack    <= 1'b0;
      r_starve_cnt <= 8'd0;
      r_cpu_starve <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cpu_ack    <= (w_state_nxt == C_WR) || (w_state_nxt == C_ACK);
      r_starve_cnt <= w_starve_nxt;
      r_cpu_starve <= (w_starve_nxt >= STARVE_THR);
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vram_adr  <= '0;
      r_vram_we   <= 1'b0;
      r_vram_wdat <= '0;
      r_tag0      <= OWN_NONE;
      r_tag1      <= OWN_NONE;
    end else begin
      r_tag1 <= r_tag0;
      if (bus.vid_req) begin
        r_vram_adr <= bus.vid_adr;
        r_vram_we  <= 1'b0;
        r_tag0     <= OWN_VID;
      end else if (w_drain) begin
        r_vram_adr  <= w_drain_adr;
        r_vram_wdat <= w_drain_dat;
        r_vram_we   <= 1'b1;
        r_tag0      <= OWN_NONE;
      end else if (w_cpu_bus) begin
        r_vram_adr <= bus.cpu_adr;
        r_vram_we  <= bus.cpu_we;
        if (bus.cpu_we) begin
          r_vram_wdat <= bus.cpu_wdat;
          r_tag0      <= OWN_NONE;
        end else begin
          r_tag0      <= OWN_CPU;
        end
      end else begin
        r_vram_we <= 1'b0;
        r_tag0    <= OWN_NONE;
      end
    end
  end

  // Second tag stage lines up with the cycle vram_dat_in carries that access's data.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vid_dat   <= '0;
      r_vid_valid <= 1'b0;
      r_cpu_rdat  <= '0;
    end else begin
      r_vid_valid <= (r_tag1 == OWN_VID);
      if (r_tag1 == OWN_VID) begin
        r_vid_dat <= bus.vram_dat_in;
      end
      if (r_tag1 == OWN_CPU) begin
        r_cpu_rdat <= bus.vram_dat_in;
      end
    end
  end

  assign bus.vram_adr   = r_vram_adr;
  assign bus.vram_we    = r_vram_we;
  assign bus.vram_wdat  = r_vram_wdat;
  assign bus.vid_dat    = r_vid_dat;
  assign bus.vid_valid  = r_vid_valid;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.cpu_rdat   = r_cpu_rdat;
  assign bus.cpu_starve = r_cpu_starve;
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: expected video data, CPU acks and VRAM writes
// are queued with their due cycle when stimulus is driven and matched as they appear.
module tb_vram_arbiter;
  import zed64_vram_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;

  typedef struct { logic [DW-1:0] dat; int due; bit chk; } rd_exp_t;
  typedef struct { logic [AW-1:0] adr; logic [DW-1:0] dat; int due; } wr_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc_n = 0;

  rd_exp_t vid_q[$];
  rd_exp_t cpu_q[$];
  wr_exp_t wr_q[$];

  logic [DW-1:0] mem   [0:(1<<AW)-1];
  bit            wflag [0:(1<<AW)-1];

  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) vif ();

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(64)) dut (
    .pixel_clock (clk),
    .reset_n     (rst_n),
    .bus         (vif)
  );

  // Synchronous VRAM, 1-cycle read; unwritten locations read back adr[7:0]
  always @(posedge clk) begin
    if (vif.vram_we) begin
      mem[vif.vram_adr]   <= vif.vram_wdat;
      wflag[vif.vram_adr] <= 1'b1;
    end
    vif.vram_dat_in <= wflag[vif.vram_adr] ? mem[vif.vram_adr] : vif.vram_adr[7:0];
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  // Advance one cycle and match whatever the DUT produced against the scoreboards
  task automatic cycle();
    rd_exp_t r;
    wr_exp_t w;
    @(posedge clk);
    #1;
    cyc_n++;
    if (vif.vid_valid === 1'b1) begin
      checks++;
      if (vid_q.size() == 0) begin
        errors++;
        $display("FAIL vid_unexpected cyc=%0d got dat=%h, none expected", cyc_n, vif.vid_dat);
      end else begin
        r = vid_q.pop_front();
        if (vif.vid_dat !== r.dat || cyc_n != r.due) begin
          errors++;
          $display("FAIL vid_data got dat=%h at cyc %0d, need dat=%h at cyc %0d", vif.vid_dat, cyc_n, r.dat, r.due);
        end
      end
    end else if (vid_q.size() > 0 && vid_q[0].due <= cyc_n) begin
      checks++; errors++;
      $display("FAIL vid_missing got no vid_valid at cyc %0d, need dat=%h", cyc_n, vid_q[0].dat);
      void'(vid_q.pop_front());
    end
    if (vif.cpu_ack === 1'b1) begin
      vif.cpu_req = 1'b0;
      checks++;
      if (cpu_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_ack_unexpected cyc=%0d got ack, none expected", cyc_n);
      end else begin
        r = cpu_q.pop_front();
        if (cyc_n != r.due || (r.chk && vif.cpu_rdat !== r.dat)) begin
          errors++;
          $display("FAIL cpu_ack got rdat=%h at cyc %0d, need rdat=%h at cyc %0d", vif.cpu_rdat, cyc_n, r.dat, r.due);
        end
      end
    end else if (cpu_q.size() > 0 && cpu_q[0].due <= cyc_n) begin
      checks++; errors++;
      $display("FAIL cpu_ack_missing got no ack at cyc %0d, need ack due %0d", cyc_n, cpu_q[0].due);
      void'(cpu_q.pop_front());
    end
    if (vif.vram_we === 1'b1) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL vram_wr_unexpected cyc=%0d got adr=%h dat=%h", cyc_n, vif.vram_adr, vif.vram_wdat);
      end else begin
        w = wr_q.pop_front();
        if (vif.vram_adr !== w.adr || vif.vram_wdat !== w.dat || cyc_n != w.due) begin
          errors++;
          $display("FAIL vram_wr got adr=%h dat=%h cyc %0d, need adr=%h dat=%h cyc %0d",
                   vif.vram_adr, vif.vram_wdat, cyc_n, w.adr, w.dat, w.due);
        end
      end
    end else if (wr_q.size() > 0 && wr_q[0].due <= cyc_n) begin
      checks++; errors++;
      $display("FAIL vram_wr_missing got no write at cyc %0d, need adr=%h", cyc_n, wr_q[0].adr);
      void'(wr_q.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    checks++; if (vif.vram_adr !== 13'h0000) begin errors++; $display("FAIL rst_vram_adr got %h need 0", vif.vram_adr); end
    checks++; if (vif.vram_we !== 1'b0) begin errors++; $display("FAIL rst_vram_we got %b need 0", vif.vram_we); end
    checks++; if (vif.vram_wdat !== 8'h00) begin errors++; $display("FAIL rst_vram_wdat got %h need 0", vif.vram_wdat); end
    checks++; if (vif.vid_dat !== 8'h00 || vif.vid_valid !== 1'b0) begin errors++; $display("FAIL rst_vid got %h/%b need 0/0", vif.vid_dat, vif.vid_valid); end
    checks++; if (vif.cpu_ack !== 1'b0 || vif.cpu_rdat !== 8'h00) begin errors++; $display("FAIL rst_cpu got %b/%h need 0/0", vif.cpu_ack, vif.cpu_rdat); end
    checks++; if (vif.cpu_starve !== 1'b0) begin errors++; $display("FAIL rst_starve got %b need 0", vif.cpu_starve); end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_video_stream();
    for (int i = 0; i < 8; i++) begin
      vif.vid_req = 1'b1;
      vif.vid_adr = 13'(i);
      vid_q.push_back('{dat: 8'(i), due: cyc_n + 3, chk: 1'b1});
      cycle();
    end
    vif.vid_req = 1'b0;
    repeat (4) cycle();
    checks++;
    if (vid_q.size() != 0) begin errors++; $display("FAIL video_stream_left got %0d pending need 0", vid_q.size()); end
  endtask

  task automatic test_cpu_read();
    vif.cpu_req = 1'b1;
    vif.cpu_we  = 1'b0;
    vif.cpu_adr = 13'h1ABC;
    cpu_q.push_back('{dat: 8'hBC, due: cyc_n + 3, chk: 1'b1});
    cycle();
    checks++;
    if (vif.vram_adr !== 13'h1ABC || vif.vram_we !== 1'b0) begin
      errors++; $display("FAIL cpu_read_bus got adr=%h we=%b need 1abc/0", vif.vram_adr, vif.vram_we);
    end
    repeat (4) cycle();
    checks++;
    if (cpu_q.size() != 0) begin errors++; $display("FAIL cpu_read_left got %0d pending need 0", cpu_q.size()); end
  endtask

  task automatic test_write_under_video();
    int c0;
    int ack_off;
`ifdef VRAM_ARB_WPOST_EN
    ack_off = 1;
`else
    ack_off = 11;
`endif
    c0 = cyc_n;
    wr_q.push_back('{adr: 13'h0123, dat: 8'h5A, due: c0 + 11});
    cpu_q.push_back('{dat: 8'h00, due: c0 + ack_off, chk: 1'b0});
    vif.cpu_req  = 1'b1;
    vif.cpu_we   = 1'b1;
    vif.cpu_adr  = 13'h0123;
    vif.cpu_wdat = 8'h5A;
    for (int t = 0; t < 16; t++) begin
      vif.vid_req = (t < 10);
      vif.vid_adr = 13'h0040 + 13'(t);
      if (t < 10) vid_q.push_back('{dat: 8'h40 + 8'(t), due: cyc_n + 3, chk: 1'b1});
      cycle();
      checks++;
      if (vif.cpu_starve !== 1'b0) begin errors++; $display("FAIL wr_starve cyc %0d got %b need 0", cyc_n, vif.cpu_starve); end
    end
    vif.cpu_req = 1'b1;
    vif.cpu_we  = 1'b0;
    cpu_q.push_back('{dat: 8'h5A, due: cyc_n + 3, chk: 1'b1});
    repeat (5) cycle();
    checks++;
    if (cpu_q.size() != 0 || wr_q.size() != 0) begin
      errors++; $display("FAIL wr_video_left got cpu=%0d wr=%0d pending need 0", cpu_q.size(), wr_q.size());
    end
  endtask

  task automatic test_starve();
    int  c0;
    bit  exp_s;
    c0 = cyc_n;
    vif.cpu_req = 1'b1;
    vif.cpu_we  = 1'b0;
    vif.cpu_adr = 13'h0042;
    cpu_q.push_back('{dat: 8'h42, due: c0 + 73, chk: 1'b1});
    for (int k = 0; k <= 70; k++) begin
      vif.vid_req = (k < 70);
      vif.vid_adr = 13'h0200 + 13'(k);
      if (k < 70) vid_q.push_back('{dat: 8'(k), due: cyc_n + 3, chk: 1'b1});
      cycle();
      exp_s = ((k + 1) >= 64) && ((k + 1) <= 70);
      checks++;
      if (vif.cpu_starve !== exp_s) begin
        errors++; $display("FAIL starve wait=%0d got %b need %b", k + 1, vif.cpu_starve, exp_s);
      end
    end
    repeat (5) cycle();
    checks++;
    if (cpu_q.size() != 0 || vid_q.size() != 0) begin
      errors++; $display("FAIL starve_left got cpu=%0d vid=%0d pending need 0", cpu_q.size(), vid_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    int acks;
    vif.cpu_req = 1'b1;
    vif.cpu_we  = 1'b0;
    vif.cpu_adr = 13'h0777;
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vif.vram_adr, vif.vram_we, vif.vram_wdat} !== 22'h0) begin
      errors++; $display("FAIL midrst_vram got adr=%h we=%b wdat=%h need 0", vif.vram_adr, vif.vram_we, vif.vram_wdat);
    end
    checks++;
    if ({vif.vid_dat, vif.vid_valid, vif.cpu_ack, vif.cpu_rdat, vif.cpu_starve} !== 19'h0) begin
      errors++; $display("FAIL midrst_out got vid=%h/%b ack=%b rdat=%h starve=%b need 0",
                         vif.vid_dat, vif.vid_valid, vif.cpu_ack, vif.cpu_rdat, vif.cpu_starve);
    end
    vif.cpu_req = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (vif.cpu_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL midrst_ack got %0d acks need 0", acks); end
    vif.vid_req = 1'b1;
    vif.vid_adr = 13'h0055;
    vid_q.push_back('{dat: 8'h55, due: cyc_n + 3, chk: 1'b1});
    cycle();
    vif.vid_req = 1'b0;
    repeat (4) cycle();
    checks++;
    if (vid_q.size() != 0) begin errors++; $display("FAIL midrst_vid_left got %0d pending need 0", vid_q.size()); end
  endtask

`ifdef VRAM_ARB_WPOST_EN
  task automatic test_wpost();
    int c0;
    int j;
    int ack_off [0:4];
    ack_off = '{1, 3, 5, 7, 15};
    c0 = cyc_n;
    j  = 0;
    for (int w = 0; w < 5; w++) begin
      wr_q.push_back('{adr: 13'h0300 + 13'(w), dat: 8'hA0 + 8'(w), due: c0 + 14 + w});
      cpu_q.push_back('{dat: 8'h00, due: c0 + ack_off[w], chk: 1'b0});
    end
    cpu_q.push_back('{dat: 8'hA4, due: c0 + 21, chk: 1'b1});
    for (int t = 0; t < 28; t++) begin
      vif.vid_req = (t < 13);
      vif.vid_adr = 13'h0100 + 13'(t);
      if (t < 13) vid_q.push_back('{dat: 8'(t), due: cyc_n + 3, chk: 1'b1});
      if (!vif.cpu_req && j < 6) begin
        vif.cpu_req  = 1'b1;
        vif.cpu_we   = (j < 5);
        vif.cpu_adr  = (j < 5) ? (13'h0300 + 13'(j)) : 13'h0304;
        vif.cpu_wdat = 8'hA0 + 8'(j);
        j++;
      end
      cycle();
    end
    checks++;
    if (cpu_q.size() != 0 || wr_q.size() != 0 || vid_q.size() != 0) begin
      errors++; $display("FAIL wpost_left got cpu=%0d wr=%0d vid=%0d pending need 0", cpu_q.size(), wr_q.size(), vid_q.size());
    end
  endtask
`endif

  initial begin
    vif.vid_req  = 1'b0;
    vif.vid_adr  = '0;
    vif.cpu_req  = 1'b0;
    vif.cpu_we   = 1'b0;
    vif.cpu_adr  = '0;
    vif.cpu_wdat = '0;
    test_reset();
    test_video_stream();
    test_cpu_read();
    test_write_under_video();
    test_starve();
    test_reset_mid_read();
`ifdef VRAM_ARB_WPOST_EN
    test_wpost();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
